ascon_arb: RTL and testbench

ASCON_ARB -- requirements
Module: ascon_arb

---
 rtl/ascon_pkg.sv | 20 ++
 rtl/rr_pick2.sv | 21 ++
 rtl/ascon_arb.sv | 171 +++++++++++++++++
 tb/tb_ascon_arb.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// Shared definitions for the ASCON core arbiter: word-class encoding and
// arbiter state constants.
package ascon_pkg;

    // Word class carried alongside every input word.
    typedef enum logic [1:0] {
        PH_KEY   = 2'd0,
        PH_NONCE = 2'd1,
        PH_ASSOC = 2'd2,
        PH_TEXT  = 2'd3
    } phase_t;

    // Arbiter state enumeration, kept as plain constants so existing
    // legacy code that compares raw state values keeps working.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: the requester after last_winner gets first
// priority; a lone requester always wins. Purely combinational.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last_winner,
    output logic [1:0] gnt
);

    // Priority rotates away from whoever won last.
    always_comb begin
        gnt = '0;
        if (last_winner) begin
            if (req[0])      gnt = 2'b01;
            else if (req[1]) gnt = 2'b10;
        end else begin
            if (req[1])      gnt = 2'b10;
            else if (req[0]) gnt = 2'b01;
        end
    end

endmodule

// File: rtl/ascon_arb.sv
// Two-requester arbiter in front of a single ASCON core. A granted
// requester owns the core for a whole job (input words through tag);
// the core is reset between jobs.
// Optional feature: define ASCON_ARB_TIMEOUT_EN to enable the stall
// watchdog that aborts a job after TIMEOUT cycles without progress.
module ascon_arb
    import ascon_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req,
    output logic [1:0]   gnt,
    input  logic [1:0]   s_mode,
    input  logic [63:0]  s_data,
    input  logic [3:0]   s_phase,
    input  logic [1:0]   s_valid,
    input  logic [1:0]   s_last,
    output logic [1:0]   s_ready,
    output logic [31:0]  m_data,
    output logic [1:0]   m_valid,
    output logic [1:0]   m_last,
    output logic [127:0] m_tag,
    output logic [1:0]   m_tag_valid,
    output logic         c_rst,
    output logic         c_mode,
    output logic [31:0]  c_data,
    output logic [1:0]   c_phase,
    output logic         c_valid,
    output logic         c_last,
    input  logic         c_ready,
    input  logic [31:0]  c_out,
    input  logic         c_out_valid,
    input  logic         c_out_last,
    input  logic [127:0] c_tag,
    input  logic         c_tag_valid,
    output logic [1:0]   err
);

    logic [1:0] state;
    logic [1:0] gnt_q;
    logic       last_winner;
    logic       mode_q;
    logic [1:0] pick;
    logic       g;
    logic       in_run;
    logic       in_drain;
    logic       wd_fire;

    // Index of the current owner; only meaningful while gnt_q is non-zero.
    assign g        = gnt_q[1];
    assign in_run   = !rst && (state == ST_RUN);
    assign in_drain = !rst && (state == ST_DRAIN);

    rr_pick2 u_pick (
        .req         (req),
        .last_winner (last_winner),
        .gnt         (pick)
    );

`ifdef ASCON_ARB_TIMEOUT_EN
    localparam int unsigned WDW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [WDW-1:0] wdog;
    logic [1:0]     err_q;
    logic           wd_busy;
    logic           wd_event;

    // Progress is any accepted input word, any core output word, or the tag.
    assign wd_busy  = (state == ST_RUN) || (state == ST_DRAIN);
    assign wd_event = (c_valid && c_ready) || c_out_valid
                   || ((state == ST_DRAIN) && c_tag_valid);
    assign wd_fire  = wd_busy && !wd_event && (wdog == WDW'(TIMEOUT - 1));

    // Count consecutive no-progress cycles while a job owns the core.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog <= '0;
        end else if (wd_busy && !wd_event && !wd_fire) begin
            wdog <= wdog + 1'b1;
        end else begin
            wdog <= '0;
        end
    end

    // Sticky abort flag per requester, cleared when that requester is regranted.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= '0;
        end else if ((state == ST_IDLE) && (req != '0)) begin
            err_q[pick[1]] <= 1'b0;
        end else if (wd_fire) begin
            err_q[g] <= 1'b1;
        end
    end

    assign err = err_q;
`else
    // Parameter only matters with the watchdog; keep it referenced.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign wd_fire        = 1'b0;
    assign err            = '0;
`endif

    // Job sequencing: grant, stream words, wait for tag, reset core, release.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            gnt_q       <= '0;
            last_winner <= 1'b1;
            mode_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req != '0) begin
                        state       <= ST_RUN;
                        gnt_q       <= pick;
                        last_winner <= pick[1];
                        mode_q      <= pick[1] ? s_mode[1] : s_mode[0];
                    end
                end
                ST_RUN: begin
                    if (wd_fire)
                        state <= ST_RELEASE;
                    else if (s_valid[g] && c_ready && s_last[g])
                        state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (wd_fire || c_tag_valid)
                        state <= ST_RELEASE;
                end
                default: begin
                    state <= ST_IDLE;
                    gnt_q <= '0;
                end
            endcase
        end
    end

    // Zero-latency routing between the owner and the core.
    always_comb begin
        s_ready     = '0;
        m_valid     = '0;
        m_last      = '0;
        m_tag_valid = '0;
        c_valid     = 1'b0;
        c_last      = 1'b0;
        c_data      = g ? s_data[63:32] : s_data[31:0];
        c_phase     = g ? s_phase[3:2]  : s_phase[1:0];
        if (in_run) begin
            c_valid    = s_valid[g];
            c_last     = s_last[g];
            s_ready[g] = c_ready;
        end
        if (in_run || in_drain) begin
            m_valid[g] = c_out_valid;
            m_last[g]  = c_out_last;
        end
        if (in_drain)
            m_tag_valid[g] = c_tag_valid;
    end

    assign gnt    = gnt_q;
    assign c_mode = mode_q;
    assign c_rst  = rst || (state == ST_RELEASE);
    assign m_data = c_out;
    assign m_tag  = c_tag;

endmodule

// File: tb/tb_ascon_arb.sv
// Self-checking bench for ascon_arb: directed job sequences with random
// payloads, checked against a round-robin ownership model.
module tb_ascon_arb;

`ifdef ASCON_ARB_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 16;
`else
    localparam int unsigned TB_TIMEOUT = 1024;
`endif

    logic         clk;
    logic         rst;
    logic [1:0]   req;
    logic [1:0]   gnt;
    logic [1:0]   s_mode;
    logic [63:0]  s_data;
    logic [3:0]   s_phase;
    logic [1:0]   s_valid;
    logic [1:0]   s_last;
    logic [1:0]   s_ready;
    logic [31:0]  m_data;
    logic [1:0]   m_valid;
    logic [1:0]   m_last;
    logic [127:0] m_tag;
    logic [1:0]   m_tag_valid;
    logic         c_rst;
    logic         c_mode;
    logic [31:0]  c_data;
    logic [1:0]   c_phase;
    logic         c_valid;
    logic         c_last;
    logic         c_ready;
    logic [31:0]  c_out;
    logic         c_out_valid;
    logic         c_out_last;
    logic [127:0] c_tag;
    logic         c_tag_valid;
    logic [1:0]   err;

    int checks = 0;
    int errors = 0;
    int model_last = 1;

    ascon_arb #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt),
        .s_mode(s_mode), .s_data(s_data), .s_phase(s_phase),
        .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
        .m_tag(m_tag), .m_tag_valid(m_tag_valid),
        .c_rst(c_rst), .c_mode(c_mode), .c_data(c_data), .c_phase(c_phase),
        .c_valid(c_valid), .c_last(c_last), .c_ready(c_ready),
        .c_out(c_out), .c_out_valid(c_out_valid), .c_out_last(c_out_last),
        .c_tag(c_tag), .c_tag_valid(c_tag_valid), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Owner choice: scan requesters starting just after the previous winner.
    function automatic int model_pick(input logic [1:0] r, input int last);
        for (int k = 1; k <= 2; k++) begin
            int c;
            c = (last + k) % 2;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [1:0] onehot(input int i);
        logic [1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input logic [1:0] r, input int nwords, input int stall_at);
        int own;
        logic exp_mode;
        logic [31:0] w;
        logic [31:0] ow;
        logic [1:0] ph;
        logic lst;
        logic [127:0] t;
        own = model_pick(r, model_last);
        model_last = own;
        req = r;
        s_mode = 2'($urandom);
        exp_mode = s_mode[own];
        tick();
        check("grant", {126'b0, gnt}, {126'b0, onehot(own)});
        check("c_mode", {127'b0, c_mode}, {127'b0, exp_mode});
        s_mode = ~s_mode;
        c_tag_valid = 1'b1;
        #1;
        check("tag_in_run", {126'b0, m_tag_valid}, 128'd0);
        c_tag_valid = 1'b0;
        for (int i = 0; i < nwords; i++) begin
            w = $urandom;
            if (w == 32'hDEADBEEF) w = 32'h0;
            ph  = (i >= nwords - 2) ? 2'd3 : 2'(i % 2);
            lst = (i == nwords - 1);
            s_data = '0;
            s_data[32*own +: 32] = w;
            s_data[32*(1-own) +: 32] = 32'hDEADBEEF;
            s_phase = '0;
            s_phase[2*own +: 2] = ph;
            s_valid = 2'b11;
            s_last = '0;
            s_last[own] = lst;
            if (i == stall_at) begin
                repeat (5) begin
                    c_ready = 1'b0;
                    #1;
                    check("stall_ready", {126'b0, s_ready}, 128'd0);
                    check("stall_data", {96'b0, c_data}, {96'b0, w});
                    tick();
                end
            end
            c_ready = 1'b1;
            ow = $urandom;
            c_out = ow;
            c_out_valid = 1'b1;
            #1;
            check("s_ready", {126'b0, s_ready}, {126'b0, onehot(own)});
            check("c_valid", {127'b0, c_valid}, 128'd1);
            check("c_data", {96'b0, c_data}, {96'b0, w});
            check("c_phase", {126'b0, c_phase}, {126'b0, ph});
            check("c_last", {127'b0, c_last}, {127'b0, lst});
            check("m_valid_run", {126'b0, m_valid}, {126'b0, onehot(own)});
            check("m_data", {96'b0, m_data}, {96'b0, ow});
            tick();
            c_out_valid = 1'b0;
        end
        s_last = '0;
        #1;
        check("drain_ready", {126'b0, s_ready}, 128'd0);
        check("drain_cvalid", {127'b0, c_valid}, 128'd0);
        s_valid = '0;
        c_out_valid = 1'b1;
        c_out_last = 1'b1;
        #1;
        check("m_last_drain", {126'b0, m_last}, {126'b0, onehot(own)});
        tick();
        c_out_valid = 1'b0;
        c_out_last = 1'b0;
        t = {$urandom, $urandom, $urandom, $urandom};
        c_tag = t;
        c_tag_valid = 1'b1;
        #1;
        check("m_tag_valid", {126'b0, m_tag_valid}, {126'b0, onehot(own)});
        check("m_tag", m_tag, t);
        tick();
        c_tag_valid = 1'b0;
        check("release_gnt", {126'b0, gnt}, {126'b0, onehot(own)});
        check("release_crst", {127'b0, c_rst}, 128'd1);
        check("release_tag", {126'b0, m_tag_valid}, 128'd0);
        tick();
        check("idle_gnt", {126'b0, gnt}, 128'd0);
        check("idle_crst", {127'b0, c_rst}, 128'd0);
    endtask

    initial begin
        rst = 1'b1; req = 2'b11; s_mode = '0; s_data = '0; s_phase = '0;
        s_valid = 2'b11; s_last = '0; c_ready = 1'b1; c_out = '0;
        c_out_valid = 1'b1; c_out_last = 1'b0; c_tag = '0; c_tag_valid = 1'b1;
        tick();
        tick();
        check("rst_gnt", {126'b0, gnt}, 128'd0);
        check("rst_crst", {127'b0, c_rst}, 128'd1);
        check("rst_err", {126'b0, err}, 128'd0);
        check("rst_sready", {126'b0, s_ready}, 128'd0);
        check("rst_cvalid", {127'b0, c_valid}, 128'd0);
        check("rst_mvalid", {126'b0, m_valid}, 128'd0);
        check("rst_tagv", {126'b0, m_tag_valid}, 128'd0);
        rst = 1'b0; req = '0; s_valid = '0; c_out_valid = 1'b0; c_tag_valid = 1'b0;
        model_last = 1;

        // Single requester: 8 KEY/NONCE words then 2 TEXT, stall on first TEXT.
        run_job(2'b01, 10, 8);
        req = '0;
        tick();
        check("stay_idle", {126'b0, gnt}, 128'd0);

        // Contention from reset: grants must alternate starting with 0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_last = 1;
        for (int j = 0; j < 4; j++) begin
            check("rr_order", {126'b0, onehot(model_pick(2'b11, model_last))},
                  {126'b0, (j % 2 == 0) ? 2'b01 : 2'b10});
            run_job(2'b11, 2 + int'($urandom_range(0, 4)), (j == 1) ? 1 : -1);
        end

        // A lone requester wins repeatedly regardless of rotation.
        run_job(2'b10, 3, -1);
        run_job(2'b10, 2, 0);

        // Reset while waiting for the tag must drop the job silently.
        req = 2'b01;
        model_last = model_pick(2'b01, model_last);
        tick();
        check("abort_grant", {126'b0, gnt}, 128'd1);
        s_valid = 2'b01; s_last = 2'b00;
        tick();
        s_last = 2'b01;
        tick();
        s_valid = '0; s_last = '0;
        c_tag_valid = 1'b1;
        rst = 1'b1;
        #1;
        check("abort_tag", {126'b0, m_tag_valid}, 128'd0);
        check("abort_crst", {127'b0, c_rst}, 128'd1);
        tick();
        rst = 1'b0; req = '0;
        model_last = 1;
        #1;
        check("abort_gnt", {126'b0, gnt}, 128'd0);
        check("abort_tag_idle", {126'b0, m_tag_valid}, 128'd0);
        c_tag_valid = 1'b0;
        tick();

`ifdef ASCON_ARB_TIMEOUT_EN
        // Winner stalls: abort after TIMEOUT idle cycles, other side granted.
        req = 2'b11;
        tick();
        check("wd_grant0", {126'b0, gnt}, 128'd1);
        s_valid = 2'b01; s_last = '0; c_ready = 1'b1;
        tick();
        s_valid = '0;
        repeat (15) tick();
        check("wd_err_early", {126'b0, err}, 128'd0);
        check("wd_gnt_held", {126'b0, gnt}, 128'd1);
        tick();
        check("wd_err0", {126'b0, err}, 128'd1);
        check("wd_crst", {127'b0, c_rst}, 128'd1);
        tick();
        check("wd_idle", {126'b0, gnt}, 128'd0);
        tick();
        check("wd_grant1", {126'b0, gnt}, 128'd2);
        check("wd_err_sticky", {126'b0, err}, 128'd1);
        repeat (16) tick();
        check("wd_err_both", {126'b0, err}, 128'd3);
        tick();
        tick();
        check("wd_regrant0", {126'b0, gnt}, 128'd1);
        check("wd_err_clear", {126'b0, err}, 128'd2);
        req = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
